// File: rtl/div_seq_pkg.sv
// Shared types for the iterative RV32M divider: op encoding, FSM states,
// the M-extension slice of the ALU op bundle and small op-decode helpers.
package div_seq_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Divide fields of the decoded ALU op; decode sets exactly one of these
    // for funct3[2]=1 M-extension instructions.
    typedef struct packed {
        logic div;
        logic divu;
        logic rem;
        logic remu;
    } aluop_t;

    // DIV and REM treat operands as two's complement; bit 0 of the op marks unsigned.
    function automatic logic op_is_signed(div_op_t op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder; bit 1 of the op selects it.
    function automatic logic op_is_rem(div_op_t op);
        return op[1];
    endfunction

    // Map the one-hot decode fields onto the divider op code.
    function automatic div_op_t aluop_to_div_op(aluop_t a);
        div_op_t op;
        op = DIV;
        if (a.divu)      op = DIVU;
        else if (a.rem)  op = REM;
        else if (a.remu) op = REMU;
        return op;
    endfunction

endpackage

// File: rtl/div_seq_div_step.sv
// One restoring-division step: shift {rem, quo} left by one, try to subtract
// the divisor from the partial remainder, keep the difference if it did not
// go negative and shift the success bit into the quotient.
module div_seq_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0]   w_shift;
    logic [XLEN+1:0] w_trial;
    logic            w_ge;
    logic [XLEN:0]   w_sel;
    logic            w_unused_top;

    // The shifted remainder can reach XLEN+1 bits; one more bit holds the borrow.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_trial = {1'b0, w_shift} - {2'b00, i_divisor};
    assign w_ge    = ~w_trial[XLEN+1];

    // Whichever value is kept is below the divisor, so its top bit is always zero.
    assign w_sel        = w_ge ? w_trial[XLEN:0] : w_shift;
    assign w_unused_top = w_sel[XLEN];

    assign o_rem = w_sel[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. Runs on
// magnitudes, fixes signs in a final cycle, and resolves divide-by-zero and
// signed overflow immediately at start. A flush in any state abandons the op.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            i_reset,
    input  logic            i_div_start,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_div_a,
    input  logic [XLEN-1:0] i_div_b,
    input  logic            i_div_flush,
    output logic            o_div_busy,
    output logic            o_div_done,
    output logic [XLEN-1:0] o_div_result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      r_state,   w_state_next;
    logic            r_is_rem,  w_is_rem_next;
    logic            r_neg_q,   w_neg_q_next;
    logic            r_neg_r,   w_neg_r_next;
    logic [XLEN-1:0] r_rem,     w_rem_next;
    logic [XLEN-1:0] r_quo,     w_quo_next;
    logic [XLEN-1:0] r_divisor, w_divisor_next;
    logic [XLEN-1:0] r_result,  w_result_next;
    logic [CNT_W-1:0] r_cnt,    w_cnt_next;

    div_op_t         w_op;
    logic            w_signed;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_step_rem;
    logic [XLEN-1:0] w_step_quo;

    // Operand decode for the start cycle: signs and magnitudes, special cases.
    assign w_op     = div_op_t'(i_div_op);
    assign w_signed = op_is_signed(w_op);
    assign w_sign_a = w_signed & i_div_a[XLEN-1];
    assign w_sign_b = w_signed & i_div_b[XLEN-1];
    assign w_abs_a  = w_sign_a ? -i_div_a : i_div_a;
    assign w_abs_b  = w_sign_b ? -i_div_b : i_div_b;
    assign w_b_zero = (i_div_b == '0);
    assign w_ovf    = w_signed & (i_div_a == MOST_NEG) & (i_div_b == '1);

    div_seq_div_step #(
        .XLEN(XLEN)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    // Next-state and datapath updates; a flush overrides every state.
    always_comb begin
        w_state_next   = r_state;
        w_is_rem_next  = r_is_rem;
        w_neg_q_next   = r_neg_q;
        w_neg_r_next   = r_neg_r;
        w_rem_next     = r_rem;
        w_quo_next     = r_quo;
        w_divisor_next = r_divisor;
        w_result_next  = r_result;
        w_cnt_next     = r_cnt;
        if (i_div_flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_div_start) begin
                        w_is_rem_next  = op_is_rem(w_op);
                        w_neg_q_next   = w_sign_a ^ w_sign_b;
                        w_neg_r_next   = w_sign_a;
                        w_divisor_next = w_abs_b;
                        if (w_b_zero) begin
                            w_result_next = op_is_rem(w_op) ? i_div_a : '1;
                            w_state_next  = DONE;
                        end else if (w_ovf) begin
                            w_result_next = op_is_rem(w_op) ? '0 : MOST_NEG;
                            w_state_next  = DONE;
                        end else begin
                            w_rem_next   = '0;
                            w_quo_next   = w_abs_a;
                            w_cnt_next   = CNT_W'(XLEN);
                            w_state_next = CALC;
                        end
                    end
                end
                CALC: begin
                    w_rem_next = w_step_rem;
                    w_quo_next = w_step_quo;
                    w_cnt_next = r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = FIX;
                    end
                end
                FIX: begin
                    if (r_is_rem) begin
                        w_result_next = r_neg_r ? -r_rem : r_rem;
                    end else begin
                        w_result_next = r_neg_q ? -r_quo : r_quo;
                    end
                    w_state_next = DONE;
                end
                DONE: begin
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_is_rem  <= w_is_rem_next;
            r_neg_q   <= w_neg_q_next;
            r_neg_r   <= w_neg_r_next;
            r_rem     <= w_rem_next;
            r_quo     <= w_quo_next;
            r_divisor <= w_divisor_next;
            r_result  <= w_result_next;
            r_cnt     <= w_cnt_next;
        end
    end

    // Busy covers the accepted start cycle so the pipeline stalls immediately.
    assign o_div_busy   = (r_state != IDLE) | (i_div_start & ~i_div_flush);
    assign o_div_done   = (r_state == DONE) & ~i_div_flush;
    assign o_div_result = r_result;

    // The requester is stalled while busy, so a start outside IDLE is a protocol bug.
    a_no_start_when_busy: assert property (@(posedge clk) disable iff (i_reset)
        !(i_div_start && (r_state != IDLE)));

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, randomized ops
// against an arithmetic reference, and hand sequences for flush and reset.
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_flush;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    div_seq dut (
        .clk          (clk),
        .i_reset      (reset),
        .i_div_start  (div_start),
        .i_div_op     (div_op),
        .i_div_a      (div_a),
        .i_div_b      (div_b),
        .i_div_flush  (div_flush),
        .o_div_busy   (div_busy),
        .o_div_done   (div_done),
        .o_div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (div_done) done_cnt++;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference built from the instruction-level rules using plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        if (b == 32'd0) return (op >= 2) ? a : 32'hFFFF_FFFF;
        if ((op == 0 || op == 2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (op == 2) ? 32'd0 : 32'h8000_0000;
        case (op)
            2'd0: begin sr = sa / sb; return sr; end
            2'd1: return a / b;
            2'd2: begin sr = sa % sb; return sr; end
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if ((op == 0 || op == 2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue a start during cycle 0; returns at cycle 1 (#1 after the edge).
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        div_op = op;
        div_a = a;
        div_b = b;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
    endtask

    // Run one op to completion and compare result, latency and busy/hold behaviour.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        @(negedge clk);
        div_op = op;
        div_a = a;
        div_b = b;
        div_start = 1'b1;
        #1;
        check({name, "_busy_start"}, {31'd0, div_busy}, 32'd1);
        @(posedge clk);
        #1;
        div_start = 1'b0;
        cyc = 1;
        while (!div_done && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, lat);
        check({name, "_result"}, div_result, exp);
        check({name, "_busy_done"}, {31'd0, div_busy}, 32'd1);
        @(posedge clk);
        #1;
        check({name, "_hold"}, div_result, exp);
        check({name, "_idle_busy"}, {31'd0, div_busy}, 32'd0);
        $display("op=%0d a=%h b=%h result=%h expect=%h cycles=%0d", op, a, b, div_result, exp, cyc);
    endtask

    initial begin
        int d0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        int sel;

        vecs[0] = '{2'd1, 32'd100, 32'd7, 32'd14, 34};
        vecs[1] = '{2'd3, 32'd100, 32'd7, 32'd2, 34};
        vecs[2] = '{2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34};
        vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34};
        vecs[4] = '{2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
        vecs[5] = '{2'd3, 32'd5, 32'd0, 32'd5, 1};
        vecs[6] = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
        vecs[8] = '{2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34};
        vecs[9] = '{2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 34};

        reset = 1'b1;
        div_start = 1'b0;
        div_op = 2'd0;
        div_a = '0;
        div_b = '0;
        div_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {31'd0, div_busy}, 32'd0);
        check("reset_done", {31'd0, div_done}, 32'd0);
        check("reset_result", div_result, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) rb = 32'hFFFF_FFFF;
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op($sformatf("rnd%0d", i), rop, ra, rb, ref_div(rop, ra, rb), ref_lat(rop, ra, rb));
        end

        // Flush mid-calculation: busy drops next cycle, no done, result held.
        run_op("pre_flush", 2'd1, 32'd50, 32'd5, 32'd10, 34);
        d0 = done_cnt;
        start_op(2'd1, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        div_flush = 1'b1;
        @(posedge clk);
        #1;
        div_flush = 1'b0;
        check("flush_busy_drop", {31'd0, div_busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_done", done_cnt - d0, 0);
        check("flush_result_kept", div_result, 32'd10);
        $display("flush mid-op: result=%h done_pulses=%0d", div_result, done_cnt - d0);
        run_op("after_flush", 2'd1, 32'd999, 32'd3, 32'd333, 34);

        // Start and flush together: request dropped.
        d0 = done_cnt;
        @(negedge clk);
        div_op = 2'd1;
        div_a = 32'd77;
        div_b = 32'd7;
        div_start = 1'b1;
        div_flush = 1'b1;
        #1;
        check("startflush_busy0", {31'd0, div_busy}, 32'd0);
        @(posedge clk);
        #1;
        div_start = 1'b0;
        div_flush = 1'b0;
        check("startflush_busy1", {31'd0, div_busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("startflush_no_done", done_cnt - d0, 0);
        check("startflush_result", div_result, 32'd333);
        $display("start+flush: busy=%0b done_pulses=%0d", div_busy, done_cnt - d0);

        // Flush during the done cycle: pulse suppressed, busy drops next cycle.
        d0 = done_cnt;
        start_op(2'd1, 32'd200, 32'd9);
        repeat (33) @(posedge clk);
        #1;
        div_flush = 1'b1;
        #1;
        check("flushdone_done", {31'd0, div_done}, 32'd0);
        check("flushdone_busy", {31'd0, div_busy}, 32'd1);
        @(posedge clk);
        #1;
        div_flush = 1'b0;
        check("flushdone_busy_drop", {31'd0, div_busy}, 32'd0);
        check("flushdone_no_pulse", done_cnt - d0, 0);
        $display("flush in done cycle: done_pulses=%0d", done_cnt - d0);

        // Reset mid-operation returns every output to zero.
        run_op("pre_reset", 2'd3, 32'd1000, 32'd7, 32'd6, 34);
        start_op(2'd1, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_busy", {31'd0, div_busy}, 32'd0);
        check("midreset_done", {31'd0, div_done}, 32'd0);
        check("midreset_result", div_result, 32'd0);
        $display("reset mid-op: busy=%0b done=%0b result=%h", div_busy, div_done, div_result);
        run_op("after_reset", 2'd0, 32'hFFFF_FF9C, 32'd7, ref_div(2'd0, 32'hFFFF_FF9C, 32'd7), 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
